// File: rtl/blake2_pkg.sv
// Shared types and constants for the BLAKE2s byte-stream sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: block/key sizes, FSM state enum, command encodings, length clamps.
package blake2_pkg;

  localparam int BB     = 64;          // block size in bytes
  localparam int NN_MAX = 32;          // max key / digest length in bytes
  localparam int T_W    = 64;          // byte counter width
  localparam int AW     = $clog2(BB);  // block buffer address width

  typedef enum logic [1:0] {
    CMD_DATA = 2'b00,
    CMD_CFG  = 2'b01,
    CMD_END  = 2'b10,
    CMD_RSVD = 2'b11
  } cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG2,
    ST_KEY,
    ST_MSG,
    ST_HOLD,
    ST_PAD,
    ST_COMP,
    ST_WAIT,
    ST_OUT
  } state_e;

  // Key length: anything above NN_MAX saturates.
  function automatic logic [5:0] clamp_kk(input logic [7:0] b);
    return (b > 8'(NN_MAX)) ? 6'(NN_MAX) : b[5:0];
  endfunction

  // Digest length: zero means "default", which is the full NN_MAX.
  function automatic logic [5:0] clamp_nn(input logic [7:0] b);
    return ((b == 8'd0) || (b > 8'(NN_MAX))) ? 6'(NN_MAX) : b[5:0];
  endfunction

endpackage

// File: rtl/blake2_stream_ctrl_if.sv
// Bundle of the sequencer's byte-input, block-buffer, core-control and digest signals.
// Latency: n/a (wiring only).
// Backpressure: input stream uses valid_i/ready_o; everything else is strobe based.
// Ports: master = sequencer side, slave = pins/core/buffer side.
interface blake2_stream_ctrl_if;

  logic [7:0]  data_i;
  logic [1:0]  cmd_i;
  logic        valid_i;
  logic        ready_o;

  logic        buf_we_o;
  logic [5:0]  buf_addr_o;
  logic [7:0]  buf_data_o;

  logic        core_start_o;
  logic        core_first_o;
  logic        core_last_o;
  logic [63:0] core_t_o;
  logic [5:0]  kk_o;
  logic [5:0]  nn_o;
  logic        core_done_i;

  logic [4:0]  hash_addr_o;
  logic [7:0]  hash_byte_i;
  logic [7:0]  data_o;
  logic        hash_v_o;

  modport master (
    input  data_i, cmd_i, valid_i, core_done_i, hash_byte_i,
    output ready_o, buf_we_o, buf_addr_o, buf_data_o,
           core_start_o, core_first_o, core_last_o, core_t_o, kk_o, nn_o,
           hash_addr_o, data_o, hash_v_o
  );

  modport slave (
    output data_i, cmd_i, valid_i, core_done_i, hash_byte_i,
    input  ready_o, buf_we_o, buf_addr_o, buf_data_o,
           core_start_o, core_first_o, core_last_o, core_t_o, kk_o, nn_o,
           hash_addr_o, data_o, hash_v_o
  );

endinterface

// File: rtl/blake2_pad_cnt.sv
// Block buffer fill counter and zero-pad sequencer.
// Latency: fill updates on the clock after a strobe; pad_we/pad_done are combinational from fill.
// Backpressure: none; the parent only asserts pad_en while it owns the buffer write port.
// Ports: clr/set_one/inc steer fill, pad_en runs zero-fill, full/pad_done report status.
module blake2_pad_cnt
  import blake2_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,      // new message: buffer empty
  input  logic        set_one,  // held byte written at address 0
  input  logic        inc,      // one data byte written at fill
  input  logic        pad_en,   // zero-fill towards the end of the block
  output logic [AW:0] fill,
  output logic        full,
  output logic        pad_we,
  output logic        pad_done
);

  localparam logic [AW:0] FILL_FULL = BB[AW:0];
  localparam logic [AW:0] FILL_LAST = FILL_FULL - 1'b1;

  assign full     = (fill == FILL_FULL);
  assign pad_we   = pad_en & ~full;
  // The zero write at the last address is the final pad cycle.
  assign pad_done = pad_we & (fill == FILL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
    end else if (clr) begin
      fill <= '0;
    end else if (set_one) begin
      fill <= {{AW{1'b0}}, 1'b1};
    end else if (inc || pad_we) begin
      fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/blake2_stream_ctrl.sv
// Byte-serial BLAKE2s sequencer: parses cfg/key/message bytes, fills and pads 64-byte blocks, launches compressions, streams the digest.
// Latency: buffer writes one cycle after acceptance; launch one cycle after the last block write; digest starts one cycle after final done.
// Backpressure: ready_o is high only in IDLE/CFG2/KEY/MSG, decoded from registered state (no valid_i -> ready_o path).
// Ports: clk, rst_n (async active-low), bus (master modport: input stream, buffer write, core control, digest out).
module blake2_stream_ctrl
  import blake2_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  blake2_stream_ctrl_if.master bus
);

  state_e         state_q, state_d;
  cmd_e           cmd;
  logic           acc;

  logic [5:0]     kk_q, kk_d, nn_q, nn_d;
  logic [T_W-1:0] t_q, t_d;
  logic           first_q, first_d;
  logic           last_q, last_d;
  logic           key_pad_q, key_pad_d;   // current pad closes the key block
  logic [7:0]     hold_q, hold_d;         // byte that arrived on a full buffer
  logic [4:0]     out_cnt_q, out_cnt_d;

  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     wr_data;
  logic           start;

  logic [AW:0]    fill;
  logic           full, pad_we, pad_done;
  logic           fill_clr, fill_one, fill_inc, pad_en;

  logic           buf_we_q, core_start_q, core_first_q, core_last_q;
  logic [AW-1:0]  buf_addr_q;
  logic [7:0]     buf_data_q;
  logic [T_W-1:0] core_t_q;

  assign cmd = cmd_e'(bus.cmd_i);
  assign bus.ready_o = (state_q == ST_IDLE) || (state_q == ST_CFG2) ||
                       (state_q == ST_KEY)  || (state_q == ST_MSG);
  assign acc = bus.valid_i & bus.ready_o;

  blake2_pad_cnt u_pad_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (fill_clr),
    .set_one  (fill_one),
    .inc      (fill_inc),
    .pad_en   (pad_en),
    .fill     (fill),
    .full     (full),
    .pad_we   (pad_we),
    .pad_done (pad_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    kk_d      = kk_q;
    nn_d      = nn_q;
    t_d       = t_q;
    first_d   = first_q;
    last_d    = last_q;
    key_pad_d = key_pad_q;
    hold_d    = hold_q;
    out_cnt_d = out_cnt_q;
    wr_en     = 1'b0;
    wr_addr   = fill[AW-1:0];
    wr_data   = bus.data_i;
    fill_clr  = 1'b0;
    fill_one  = 1'b0;
    fill_inc  = 1'b0;
    pad_en    = 1'b0;
    start     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (acc && cmd == CMD_CFG) begin
          kk_d    = clamp_kk(bus.data_i);
          state_d = ST_CFG2;
        end
      end
      ST_CFG2: begin
        if (acc && cmd == CMD_CFG) begin
          nn_d      = clamp_nn(bus.data_i);
          t_d       = '0;
          first_d   = 1'b1;
          last_d    = 1'b0;
          key_pad_d = 1'b0;
          fill_clr  = 1'b1;
          state_d   = (kk_q != 6'd0) ? ST_KEY : ST_MSG;
        end
      end
      ST_KEY: begin
        if (acc && cmd == CMD_DATA) begin
          wr_en    = 1'b1;
          fill_inc = 1'b1;
          if (fill == {1'b0, kk_q} - 7'd1) begin
            key_pad_d = 1'b1;
            state_d   = ST_PAD;
          end
        end
      end
      ST_MSG: begin
        if (acc) begin
          case (cmd)
            CMD_DATA: begin
              if (full) begin
                // Only now is it known that the buffered block is not the last one.
                hold_d  = bus.data_i;
                last_d  = 1'b0;
                state_d = ST_COMP;
              end else begin
                wr_en    = 1'b1;
                fill_inc = 1'b1;
                t_d      = t_q + 1'b1;
              end
            end
            CMD_END: begin
              last_d  = 1'b1;
              state_d = full ? ST_COMP : ST_PAD;
            end
            default: ;
          endcase
        end
      end
      ST_PAD: begin
        pad_en  = 1'b1;
        wr_en   = pad_we;
        wr_data = 8'd0;
        if (pad_done) begin
          if (key_pad_q) begin
            // Key block is parked full; it launches on the next DATA or END.
            key_pad_d = 1'b0;
            t_d       = t_q + T_W'(BB);
            state_d   = ST_MSG;
          end else begin
            state_d = ST_COMP;
          end
        end
      end
      ST_COMP: begin
        start   = 1'b1;
        first_d = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        out_cnt_d = 5'd0;
        if (bus.core_done_i) state_d = last_q ? ST_OUT : ST_HOLD;
      end
      ST_HOLD: begin
        wr_en    = 1'b1;
        wr_addr  = '0;
        wr_data  = hold_q;
        fill_one = 1'b1;
        t_d      = t_q + 1'b1;
        state_d  = ST_MSG;
      end
      ST_OUT: begin
        if ({1'b0, out_cnt_q} == nn_q - 6'd1) begin
          out_cnt_d = 5'd0;
          state_d   = ST_IDLE;
        end else begin
          out_cnt_d = out_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Buffer writes and the launch are registered so the final pad write
  // always lands one cycle ahead of core_start_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kk_q         <= '0;
      nn_q         <= '0;
      t_q          <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      key_pad_q    <= 1'b0;
      hold_q       <= '0;
      out_cnt_q    <= '0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      core_start_q <= 1'b0;
      core_first_q <= 1'b0;
      core_last_q  <= 1'b0;
      core_t_q     <= '0;
    end else begin
      kk_q         <= kk_d;
      nn_q         <= nn_d;
      t_q          <= t_d;
      first_q      <= first_d;
      last_q       <= last_d;
      key_pad_q    <= key_pad_d;
      hold_q       <= hold_d;
      out_cnt_q    <= out_cnt_d;
      buf_we_q     <= wr_en;
      if (wr_en) begin
        buf_addr_q <= wr_addr;
        buf_data_q <= wr_data;
      end
      core_start_q <= start;
      if (start) begin
        core_first_q <= first_q;
        core_last_q  <= last_q;
        core_t_q     <= t_q;
      end
    end
  end

  assign bus.buf_we_o     = buf_we_q;
  assign bus.buf_addr_o   = buf_addr_q;
  assign bus.buf_data_o   = buf_data_q;
  assign bus.core_start_o = core_start_q;
  assign bus.core_first_o = core_first_q;
  assign bus.core_last_o  = core_last_q;
  assign bus.core_t_o     = core_t_q;
  assign bus.kk_o         = kk_q;
  assign bus.nn_o         = nn_q;
  assign bus.hash_addr_o  = out_cnt_q;
  assign bus.hash_v_o     = (state_q == ST_OUT);
  assign bus.data_o       = (state_q == ST_OUT) ? bus.hash_byte_i : 8'd0;

endmodule

// File: tb/tb_blake2_stream_ctrl.sv
// Scoreboard bench for blake2_stream_ctrl with a stub compression core.
// Latency: stub core answers 1..6 cycles after a launch (longer for the reset-in-WAIT case).
// Backpressure: driver holds valid_i until ready_o, with random idle gaps.
module tb_blake2_stream_ctrl;
  import blake2_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  blake2_stream_ctrl_if bus();

  blake2_stream_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        first;
    logic        last;
    logic [63:0] t;
  } launch_t;

  launch_t      exp_launch_q[$];
  logic [511:0] exp_blk_q[$];
  logic [7:0]   exp_hash_q[$];
  int           exp_nn_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] seed = 8'h00;
  logic [7:0] key_b[32];
  logic [7:0] msg_b[256];
  logic [7:0] mem[64];
  bit         long_delay = 1'b0;

  // Stub core digest: a simple function of the byte index and a per-run seed.
  assign bus.hash_byte_i = seed + 8'(bus.hash_addr_o) * 8'd37;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_blk(input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL block_content: got %h expected %h", act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Reference model: BLAKE2 message layout (key block, then message), split
  // into 64-byte blocks, zero-padded; t is the bytes consumed so far.
  task automatic model_push(input int kk, input int nn, input int len, input bit with_hash);
    logic [7:0]   d[$];
    logic [511:0] blk;
    launch_t      l;
    int           total, nb, idx;
    if (kk > 0) for (int i = 0; i < 64; i++) d.push_back(i < kk ? key_b[i] : 8'd0);
    for (int j = 0; j < len; j++) d.push_back(msg_b[j]);
    total = d.size();
    nb = (total == 0) ? 1 : (total + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) begin
        idx = b * 64 + i;
        if (idx < total) blk[i*8 +: 8] = d[idx];
      end
      l.first = (b == 0);
      l.last  = (b == nb - 1);
      l.t     = 64'((b + 1) * 64 < total ? (b + 1) * 64 : total);
      exp_launch_q.push_back(l);
      exp_blk_q.push_back(blk);
    end
    if (with_hash) begin
      for (int i = 0; i < nn; i++) exp_hash_q.push_back(seed + 8'(i) * 8'd37);
      exp_nn_q.push_back(nn);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d, input bit gaps);
    int n = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.valid_i = 1'b1;
    bus.cmd_i   = c;
    bus.data_i  = d;
    forever begin
      @(negedge clk);
      if (bus.ready_o) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 3000) begin
        check("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_launch_q.size() != 0 || exp_nn_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("run_complete_in_budget", 64'(n < 5000), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int kk_raw, input int nn_raw, input int len, input bit noise, input bit abc);
    int kk, nn, p;
    kk = (kk_raw > 32) ? 32 : kk_raw;
    nn = (nn_raw == 0 || nn_raw > 32) ? 32 : nn_raw;
    seed = 8'($urandom);
    for (int i = 0; i < 32; i++) key_b[i] = 8'($urandom);
    for (int j = 0; j < 256; j++) msg_b[j] = 8'($urandom);
    if (abc) begin
      msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
    end
    model_push(kk, nn, len, 1'b1);
    if (noise) begin
      send(CMD_DATA, 8'($urandom), noise);   // dropped in IDLE
      send(CMD_END, 8'h00, noise);
    end
    send(CMD_CFG, 8'(kk_raw), noise);
    send(CMD_CFG, 8'(nn_raw), noise);
    for (int i = 0; i < kk; i++) begin
      if (noise && $urandom_range(0, 5) == 0) send(CMD_END, 8'h00, noise);
      send(CMD_DATA, key_b[i], noise);
    end
    for (int j = 0; j < len; j++) begin
      if (noise && $urandom_range(0, 7) == 0)
        send($urandom_range(0, 1) ? CMD_CFG : CMD_RSVD, 8'($urandom), noise);
      p = ((kk > 0) ? 64 : 0) + j;
      send(CMD_DATA, msg_b[j], noise);
      if (p > 0 && p % 64 == 0) begin
        @(negedge clk);
        check("ready_low_after_full_data", 64'(bus.ready_o), 64'd0);
      end
    end
    send(CMD_END, 8'h00, noise);
    wait_idle();
    check("kk_o", 64'(bus.kk_o), 64'(kk));
    check("nn_o", 64'(bus.nn_o), 64'(nn));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"},   64'(bus.ready_o), 64'd1);
    check({tag, "_hash_v"},  64'(bus.hash_v_o), 64'd0);
    check({tag, "_start"},   64'(bus.core_start_o), 64'd0);
    check({tag, "_buf_we"},  64'(bus.buf_we_o), 64'd0);
    check({tag, "_misc"},    64'({bus.buf_addr_o, bus.buf_data_o, bus.core_first_o, bus.core_last_o,
                                  bus.kk_o, bus.nn_o, bus.hash_addr_o, bus.data_o}), 64'd0);
    check({tag, "_core_t"},  bus.core_t_o, 64'd0);
  endtask

  // Monitor + stub core: all sampling on the falling edge.
  int  cyc = 0, done_cyc = -100, done_cnt = 0, wr_cnt = 0, hash_run = 0;
  bit  pend_last = 1'b0, prev_hv = 1'b0;
  always @(negedge clk) begin
    launch_t      l;
    logic [511:0] cur;
    logic [7:0]   eb;
    cyc++;
    bus.core_done_i = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        bus.core_done_i = 1'b1;
        if (pend_last) done_cyc = cyc;
      end
    end
    if (!rst_n) begin
      wr_cnt   = 0;
      hash_run = 0;
      prev_hv  = 1'b0;
    end else begin
      if (bus.buf_we_o) begin
        mem[bus.buf_addr_o] = bus.buf_data_o;
        wr_cnt++;
      end
      if (bus.core_start_o) begin
        if (exp_launch_q.size() == 0) fail_evt("unexpected_launch");
        else begin
          l = exp_launch_q.pop_front();
          check("launch_first", 64'(bus.core_first_o), 64'(l.first));
          check("launch_last",  64'(bus.core_last_o),  64'(l.last));
          check("launch_t",     bus.core_t_o, l.t);
          check("writes_per_block", 64'(wr_cnt), 64'd64);
          for (int i = 0; i < 64; i++) cur[i*8 +: 8] = mem[i];
          check_blk(cur, exp_blk_q.pop_front());
          pend_last = l.last;
        end
        wr_cnt   = 0;
        done_cnt = long_delay ? 20 : $urandom_range(1, 6);
      end
      if (bus.hash_v_o) begin
        if (!prev_hv) check("done_to_hash_v", 64'(cyc - done_cyc), 64'd1);
        hash_run++;
        if (exp_hash_q.size() == 0) fail_evt("unexpected_hash_v");
        else begin
          eb = exp_hash_q.pop_front();
          check("digest_byte", 64'(bus.data_o), 64'(eb));
        end
      end else if (prev_hv) begin
        if (exp_nn_q.size() == 0) fail_evt("unexpected_hash_run");
        else check("hash_v_cycles", 64'(hash_run), 64'(exp_nn_q.pop_front()));
        hash_run = 0;
      end
      prev_hv = bus.hash_v_o;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.valid_i = 1'b0;
    bus.cmd_i   = 2'b00;
    bus.data_i  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(0, 32, 3, 1'b0, 1'b1);    // "abc"
    run(0, 32, 0, 1'b0, 1'b0);    // empty message: 64 pad writes, t=0
    run(0, 32, 64, 1'b0, 1'b0);   // exactly full: no pad, t=64
    run(0, 32, 65, 1'b0, 1'b0);   // spill: held byte, then 63 pad
    run(3, 16, 0, 1'b0, 1'b0);    // key only
    run(40, 0, 5, 1'b1, 1'b0);    // clamped kk, default nn
    run(32, 1, 128, 1'b1, 1'b0);
    for (int r = 0; r < 14; r++)
      run($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 150), 1'b1, 1'b0);

    // Reset while the core is busy: no digest afterwards, new config accepted.
    long_delay = 1'b1;
    seed = 8'($urandom);
    for (int j = 0; j < 10; j++) msg_b[j] = 8'($urandom);
    model_push(0, 32, 10, 1'b0);
    send(CMD_CFG, 8'd0, 1'b0);
    send(CMD_CFG, 8'd32, 1'b0);
    for (int j = 0; j < 10; j++) send(CMD_DATA, msg_b[j], 1'b0);
    send(CMD_END, 8'h00, 1'b0);
    n = 0;
    while (exp_launch_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reset_case_launch_seen", 64'(n < 500), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outs("midwait_reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    long_delay = 1'b0;
    repeat (30) @(negedge clk);
    check("no_hash_after_reset", 64'(bus.hash_v_o), 64'd0);
    @(posedge clk);
    #1;
    run(2, 8, 20, 1'b0, 1'b0);

    check("leftover_launches", 64'(exp_launch_q.size()), 64'd0);
    check("leftover_digest",   64'(exp_hash_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/blake2_stream_ctrl.md
# blake2_stream_ctrl

Byte-serial sequencer sitting between the tile's 8-bit I/O pins and the BLAKE2s compression core inside `tt_um_essen`. It parses config, key and message bytes, fills the 64-byte block buffer with zero padding, and launches each compression with the correct first/last flags and byte counter `t`. After the final compression it streams the `nn`-byte digest out with `hash_v`.

## Interface
- `BB`, 64: block size in bytes; buffer address width is log2(BB).
- `NN_MAX`, 32: maximum key and digest length in bytes.
- `T_W`, 64: width of the byte counter `t`.

- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_i` in 8: input byte.
- `cmd_i` in 2: 00 DATA, 01 CFG, 10 END, 11 reserved (dropped).
- `valid_i` in 1: input byte/command valid.
- `ready_o` out 1: input accepted when `valid_i & ready_o`.
- `buf_we_o` out 1: block buffer write strobe.
- `buf_addr_o` out 6: block buffer byte address.
- `buf_data_o` out 8: block buffer write data.
- `core_start_o` out 1: one-cycle compression launch pulse.
- `core_first_o` out 1: first block; core initialises `h` from `kk`/`nn`.
- `core_last_o` out 1: final block flag.
- `core_t_o` out 64: byte count including this block.
- `kk_o` out 6: key length.
- `nn_o` out 6: digest length.
- `core_done_i` in 1: compression complete, one-cycle pulse.
- `hash_addr_o` out 5: digest byte index.
- `hash_byte_i` in 8: digest byte at `hash_addr_o`, combinational, same cycle.
- `data_o` out 8: digest output byte.
- `hash_v_o` out 1: `data_o` valid.

## Operation
- States: IDLE, CFG2, KEY, MSG, HOLD, PAD, COMP, WAIT, OUT.
- IDLE: a CFG byte latches `kk` (clamped to 32), then goes to CFG2. DATA/END are accepted and dropped.
- CFG2: a CFG byte latches `nn`; 0 or >32 becomes 32. Go to KEY if `kk>0`, else MSG. `t`, `fill`, `first` are cleared.
- KEY: each DATA byte is written at `fill` and increments `fill`. After `kk` bytes, PAD zero-fills to 63 and `t += 64`. Buffer is then full; go to MSG. END/CFG are dropped.
- MSG: a DATA byte when not full writes at `fill`, then `fill++`, `t++`.
  - DATA when full (`fill==64`): the byte is latched in a hold register. COMP issues a non-final launch, WAIT for done, then HOLD writes the byte at address 0 with `fill=1`, `t++`.
  - END with `0<fill<64`: PAD to 63, then a final launch.
  - END with full buffer: immediate final launch.
  - END with `fill==0` (only when `kk==0` and no data): PAD all 64 bytes, then a final launch with `t=0`.
  - CFG in MSG is dropped.
- Full buffers are never compressed until the next DATA or END arrives, so `core_last_o` is always correct.
- COMP: `core_start_o` is high for one cycle. `core_first_o=first`, then `first` is cleared. `core_t_o=t`.
- WAIT: waits for `core_done_i`. If non-final, go to HOLD. If final, go to OUT.
- OUT: counts `hash_addr_o` from 0 to `nn-1`, one byte per cycle, with `data_o=hash_byte_i` and `hash_v_o=1`. Then go to IDLE.
- `t` wraps modulo 2^64.
- `kk_o`/`nn_o` hold their latched values until the next config.

## Timing
- Reset values: `ready_o`=1, `hash_v_o`=0, `core_start_o`=0, `buf_we_o`=0, all other outputs 0. State resets to IDLE.
- `ready_o` is high only in IDLE, CFG2, KEY and MSG. It is decoded from the registered state, so there is no combinational path from `valid_i`.
- DATA write: `buf_we_o` is asserted in the cycle after acceptance.
- Pad latency: `64-fill` cycles with one zero write each. `core_start_o` follows in the next cycle.
- Final done to first `hash_v_o`: 1 cycle. `hash_v_o` stays high for exactly `nn` consecutive cycles.
- `core_done_i` outside WAIT is ignored.
- Reset mid-operation (any state) returns to IDLE. The buffer contents are don't-care, and no further launch occurs.

## Structure
- `blake2_pkg` holds:
  - the state enum
  - the command encodings `CMD_DATA`/`CMD_CFG`/`CMD_END`
  - `BB`, `NN_MAX`
- Natural sub-module: `blake2_pad_cnt`, which owns the `fill` address counter and zero-fill sequencing, and reports `full` and `pad_done`.

## Test plan
- CFG 0, CFG 32, DATA "abc", END:
  - writes at addresses 0–2, then 61 zero writes;
  - one launch with first=1, last=1, t=3;
  - with the reference core, 32 output bytes starting 0x50 0x8C 0x5E.
- CFG 0, CFG 32, END: 64 zero writes, then a launch with first=1, last=1, t=0.
- 64 DATA bytes then END: no launch until END, then an immediate launch with last=1, t=64 and no pad writes.
- 65 DATA bytes then END:
  - 65th byte drops `ready_o` and triggers a launch with first=1, last=0, t=64;
  - after done, the byte is written at address 0;
  - END pads 63 bytes, then a launch with first=0, last=1, t=65.
- CFG 3, CFG 16, 3 key bytes, END:
  - pad 61 bytes; END then triggers a launch with first=1, last=1, t=64;
  - exactly 16 `hash_v_o` cycles.
- Assert `rst_n`=0 during WAIT:
  - outputs return to reset values immediately;
  - a later `core_done_i` produces no `hash_v_o`;
  - a new CFG is accepted.
